// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit shifter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } tx_state_t;

   localparam int FRAME_BITS           = 10;
   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: one-cycle tick every CLKS_PER_BIT clocks while clear is low.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == TERM);

   always_ff @(posedge clk) begin
      if (reset || clear) cnt <= '0;
      else if (tick)      cnt <= '0;
      else                cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_tx_shifter.sv
// 8N1 UART transmitter: accepts a byte on TX_load, shifts it out LSB first,
// then parks in DONE until TX_load drops so a held request cannot retrigger.
module uart_tx_shifter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TX_load,
   input  logic [7:0] tx_data,
   output logic       COUNT,
   output logic       tx_serial
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   tx_state_t             state, state_nxt;
   logic [FRAME_BITS-1:0] shreg;
   logic [3:0]            bit_cnt;
   logic                  tick;
   logic                  baud_clear;

   // Baud counter only runs during SHIFT, so every frame starts at count 0.
   assign baud_clear = (state != SHIFT);

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (TX_load) state_nxt = SHIFT;
         SHIFT:   if (tick && bit_cnt == LAST_BIT) state_nxt = DONE;
         DONE:    if (!TX_load) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '1;
         bit_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (TX_load) begin
                  shreg   <= {1'b1, tx_data, 1'b0};
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (tick) begin
                  shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
                  bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // COUNT follows TX_load in IDLE so the control FSM sees it in its first cycle.
   always_comb begin
      COUNT     = 1'b0;
      tx_serial = 1'b1;
      unique case (state)
         IDLE:  COUNT = TX_load;
         SHIFT: begin
            COUNT     = 1'b1;
            tx_serial = shreg[0];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Self-checking bench for uart_tx_shifter at CLKS_PER_BIT=4.
module tb_uart_tx_shifter;

   localparam int CPB = 4;
   localparam int FRAME_CYC = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       tb_load;
   logic [7:0] tx_data;
   logic       COUNT;
   logic       tx_serial;

   // Optional TX control FSM model driving TX_load from startBTNC pulses.
   logic ctrl_mode;
   logic startBTNC;
   logic ctrl_busy;
   logic TX_load;

   int errors = 0;
   int checks = 0;

   assign TX_load = ctrl_mode ? ctrl_busy : tb_load;

   always #5 clk = ~clk;

   uart_tx_shifter #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .TX_load   (TX_load),
      .tx_data   (tx_data),
      .COUNT     (COUNT),
      .tx_serial (tx_serial)
   );

   always @(posedge clk) begin
      if (!ctrl_mode)              ctrl_busy <= 1'b0;
      else if (!ctrl_busy)         ctrl_busy <= startBTNC;
      else if (!COUNT)             ctrl_busy <= 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Line level for cycle c (0-based from the first frame cycle) of a frame carrying d.
   function automatic logic exp_bit(input logic [7:0] d, input int c);
      int idx;
      idx = c / CPB;
      if (idx == 0)      return 1'b0;
      else if (idx >= 9) return 1'b1;
      else               return d[idx-1];
   endfunction

   // hold: edges TX_load stays high after accept (1..40), or 0 to hold through DONE for linger cycles.
   task automatic send_frame(input logic [7:0] d, input int hold, input int linger, input bit ff_after);
      tx_data = d;
      tb_load = 1'b1;
      #1;
      check("accept_count", COUNT, 1);
      for (int c = 0; c < FRAME_CYC; c++) begin
         tick();
         check($sformatf("serial_%02h_c%0d", d, c), tx_serial, exp_bit(d, c));
         check("shift_count", COUNT, 1);
         if (hold != 0 && c + 1 == hold) tb_load = 1'b0;
         tx_data = ff_after ? 8'hFF : 8'($urandom);
      end
      tick();
      check("done_count", COUNT, 0);
      check("done_serial", tx_serial, 1);
      if (tb_load) begin
         for (int k = 0; k < linger; k++) begin
            tick();
            check("hold_count", COUNT, 0);
            check("hold_serial", tx_serial, 1);
         end
         tb_load = 1'b0;
      end
      tick();
      check("idle_count", COUNT, 0);
      check("idle_serial", tx_serial, 1);
   endtask

   logic q[$];

   initial begin
      int s1, s2;
      reset     = 1'b1;
      tb_load   = 1'b0;
      tx_data   = 8'h00;
      ctrl_mode = 1'b0;
      startBTNC = 1'b0;
      repeat (3) tick();
      check("rst_serial", tx_serial, 1);
      check("rst_count", COUNT, 0);
      tb_load = 1'b1;
      #1;
      check("rst_count_follows", COUNT, 1);
      tb_load = 1'b0;
      reset   = 1'b0;
      tick();

      // 0xA5 held until COUNT falls, then 20 extra cycles held in DONE
      send_frame(8'hA5, 0, 20, 1'b0);

      // single-cycle pulse of 0x00, data switched to 0xFF after accept
      send_frame(8'h00, 1, 0, 1'b1);

      // random bytes and random TX_load widths
      for (int n = 0; n < 6; n++) begin
         send_frame(8'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(0, 5)), 1'b0);
         repeat ($urandom_range(0, 3)) tick();
      end

      // reset at cycle 13 of a 0x3C frame
      tx_data = 8'h3C;
      tb_load = 1'b1;
      tick();
      tb_load = 1'b0;
      for (int c = 1; c < 13; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_serial", tx_serial, 1);
      check("midrst_count_idle0", COUNT, 0);
      tick();
      check("midrst_serial2", tx_serial, 1);
      send_frame(8'h5A, 3, 0, 1'b0);

      // two frames through the control FSM model
      ctrl_mode = 1'b1;
      tick();
      q.delete();
      tx_data   = 8'h01;
      startBTNC = 1'b1;
      tick(); q.push_back(tx_serial);
      startBTNC = 1'b0;
      for (int k = 0; k < 55; k++) begin tick(); q.push_back(tx_serial); end
      tx_data   = 8'h80;
      startBTNC = 1'b1;
      tick(); q.push_back(tx_serial);
      startBTNC = 1'b0;
      for (int k = 0; k < 60; k++) begin tick(); q.push_back(tx_serial); end
      ctrl_mode = 1'b0;

      s1 = -1;
      for (int i = 0; i < q.size(); i++) if (s1 < 0 && q[i] == 1'b0) s1 = i;
      check("ctrl_f1_found", 32'(s1 >= 0), 1);
      if (s1 >= 0) begin
         for (int c = 0; c < FRAME_CYC; c++)
            check($sformatf("ctrl_f1_c%0d", c), q[s1 + c], exp_bit(8'h01, c));
         s2 = -1;
         for (int i = s1 + FRAME_CYC; i < q.size(); i++) if (s2 < 0 && q[i] == 1'b0) s2 = i;
         check("ctrl_f2_found", 32'(s2 >= 0), 1);
         if (s2 >= 0) begin
            check("ctrl_gap_ge2", 32'(s2 - (s1 + FRAME_CYC) >= 2), 1);
            for (int c = 0; c < FRAME_CYC && s2 + c < q.size(); c++)
               check($sformatf("ctrl_f2_c%0d", c), q[s2 + c], exp_bit(8'h80, c));
         end
      end
      tick();
      check("end_serial", tx_serial, 1);
      check("end_count", COUNT, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
